// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx
//
// Serializes stereo PCM sample words into an I2S stream (bit clock, word
// select, serial data). The upstream synthesizer hands over one
// {left, right} word per frame through a valid/ready handshake. A one-cycle
// request strobe marks the frame boundary so the synthesizer can use it as
// its sample tick.
//
// Ports:
//   MasterCLK      system clock; all logic runs on its rising edge
//   Reset          synchronous, active-low reset of all state
//   SampleData     [2*SW-1:SW] left, [SW-1:0] right, two's complement
//   SampleValid    SampleData is valid this cycle
//   SampleReady    holding buffer empty; transfer on SampleValid && SampleReady
//   SampleRequest  one-cycle pulse when the buffer is loaded into the shifter
//   Underrun       one-cycle pulse when a frame load finds the buffer empty
//   BCLK           I2S bit clock, period 2*BCLK_DIV MasterCLK cycles
//   LRCLK          I2S word select, 0 = left, 1 = right
//   SDATA          I2S serial data, MSB first, one BCLK after each LRCLK edge
module audio_i2s_tx #(
  parameter int BCLK_DIV     = 4,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                      MasterCLK,
  input  logic                      Reset,
  input  logic [2*SAMPLE_WIDTH-1:0] SampleData,
  input  logic                      SampleValid,
  output logic                      SampleReady,
  output logic                      SampleRequest,
  output logic                      Underrun,
  output logic                      BCLK,
  output logic                      LRCLK,
  output logic                      SDATA
);

  localparam int FRAME_W = 2 * SAMPLE_WIDTH;
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX   = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(SAMPLE_WIDTH);

  logic [DIV_W-1:0]   r_div_cnt;
  logic               r_bclk;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic               r_lrclk;
  logic               r_sdata;
  logic [FRAME_W-1:0] r_shreg;
  logic [FRAME_W-1:0] r_buf;
  logic               r_full;
  logic               r_req;
  logic               r_unf;

  logic               w_wrap;
  logic               w_fall;
  logic [BIT_W-1:0]   w_bit_nxt;
  logic               w_load;
  logic               w_accept;
  logic [FRAME_W-1:0] w_load_val;

  assign w_wrap    = (r_div_cnt == DIV_MAX);
  // BCLK is about to go 1->0: the only event that advances the frame.
  assign w_fall    = w_wrap && r_bclk;
  assign w_bit_nxt = (r_bit_cnt == BIT_MAX) ? '0 : r_bit_cnt + 1'b1;
  // The frame starts at bit_cnt=1, giving the one-bit I2S delay after LRCLK.
  assign w_load    = w_fall && (w_bit_nxt == BIT_ONE);
  assign w_accept  = SampleValid && !r_full;
  // An empty buffer at load time yields a silent frame rather than stale data.
  assign w_load_val = r_full ? r_buf : '0;

  always_ff @(posedge MasterCLK) begin
    if (!Reset) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_bit_cnt <= '0;
      r_lrclk   <= 1'b0;
      r_sdata   <= 1'b0;
      r_shreg   <= '0;
      r_buf     <= '0;
      r_full    <= 1'b0;
      r_req     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_div_cnt <= w_wrap ? '0 : r_div_cnt + 1'b1;
      if (w_wrap) r_bclk <= ~r_bclk;

      r_req <= w_load && r_full;
      r_unf <= w_load && !r_full;

      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= (w_bit_nxt >= BIT_RIGHT);
        // The shifter keeps the bits still to be sent, left-aligned; the
        // MSB of a fresh word goes straight to SDATA on the load edge.
        if (w_load) begin
          r_sdata <= w_load_val[FRAME_W-1];
          r_shreg <= {w_load_val[FRAME_W-2:0], 1'b0};
        end else begin
          r_sdata <= r_shreg[FRAME_W-1];
          r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
        end
      end

      // Load uses the pre-cycle buffer state; a word accepted in the same
      // cycle as a load waits for the next frame (no bypass). Accept and
      // consume are mutually exclusive because accept requires empty.
      if (w_load && r_full) begin
        r_full <= 1'b0;
      end else if (w_accept) begin
        r_full <= 1'b1;
      end
      if (w_accept) r_buf <= SampleData;
    end
  end

  assign SampleReady   = ~r_full;
  assign SampleRequest = r_req;
  assign Underrun      = r_unf;
  assign BCLK          = r_bclk;
  assign LRCLK         = r_lrclk;
  assign SDATA         = r_sdata;

endmodule

// File: tb/tb_audio_i2s_tx.sv
module tb_audio_i2s_tx;

  logic        clk;
  logic        rst0, valid0, ready0, req0, unf0, bclk0, lr0, sd0;
  logic [31:0] data0;
  logic        rst1, valid1, ready1, req1, unf1, bclk1, lr1, sd1;
  logic [47:0] data1;

  int n_vec;
  int n_err;
  int cyc;

  audio_i2s_tx dut0 (
    .MasterCLK(clk), .Reset(rst0), .SampleData(data0), .SampleValid(valid0),
    .SampleReady(ready0), .SampleRequest(req0), .Underrun(unf0),
    .BCLK(bclk0), .LRCLK(lr0), .SDATA(sd0)
  );

  audio_i2s_tx #(.BCLK_DIV(1), .SAMPLE_WIDTH(24)) dut1 (
    .MasterCLK(clk), .Reset(rst1), .SampleData(data1), .SampleValid(valid1),
    .SampleReady(ready1), .SampleRequest(req1), .Underrun(unf1),
    .BCLK(bclk1), .LRCLK(lr1), .SDATA(sd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset0();
    rst0 = 1'b0; valid0 = 1'b0; data0 = '0;
    tick(); tick();
    rst0 = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst0 = 1'b0; valid0 = 1'b1; data0 = 32'hFFFF_FFFF;
    tick(); tick();
    n_vec++;
    if ({ready0, req0, unf0, bclk0, lr0, sd0} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_state: got %b expected 100000",
               {ready0, req0, unf0, bclk0, lr0, sd0});
    end
    valid0 = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] w;
    int nb, nreq, nunf;
    logic pb;
    w = '0; nb = 0; nreq = 0; nunf = 0;
    reset0();
    data0 = 32'hA5A5_3C3C; valid0 = 1'b1;
    while (cyc < 384) begin
      pb = bclk0;
      tick();
      valid0 = 1'b0;
      if (req0) nreq++;
      if (unf0) nunf++;
      if (cyc > 8 && bclk0 && !pb && nb < 32) begin
        w = {w[30:0], sd0}; nb++;
      end
      if (cyc == 3) begin
        n_vec++;
        if (bclk0 !== 1'b0) begin n_err++; $display("FAIL basic_bclk_c3: got %b expected 0", bclk0); end
      end
      if (cyc == 4) begin
        n_vec++;
        if (bclk0 !== 1'b1) begin n_err++; $display("FAIL basic_bclk_rise: got %b expected 1", bclk0); end
      end
      if (cyc == 8) begin
        n_vec++;
        if ({bclk0, req0, sd0} !== 3'b011) begin
          n_err++; $display("FAIL basic_first_load: got bclk/req/sd %b expected 011", {bclk0, req0, sd0});
        end
      end
      if (cyc == 127 || cyc == 256) begin
        n_vec++;
        if (lr0 !== 1'b0) begin n_err++; $display("FAIL basic_lrclk_low c%0d: got %b expected 0", cyc, lr0); end
      end
      if (cyc == 128 || cyc == 255 || cyc == 384) begin
        n_vec++;
        if (lr0 !== 1'b1) begin n_err++; $display("FAIL basic_lrclk_high c%0d: got %b expected 1", cyc, lr0); end
      end
    end
    n_vec++;
    if (w !== 32'hA5A5_3C3C) begin n_err++; $display("FAIL basic_frame: got %h expected a5a53c3c", w); end
    n_vec++;
    if (nreq != 1 || nunf != 1) begin
      n_err++; $display("FAIL basic_strobes: got req=%0d unf=%0d expected 1 1", nreq, nunf);
    end
  endtask

  task automatic test_underrun();
    int nreq, nunf, nones;
    nreq = 0; nunf = 0; nones = 0;
    reset0();
    while (cyc < 600) begin
      tick();
      if (req0) nreq++;
      if (unf0) nunf++;
      if (sd0) nones++;
      if (cyc == 8) begin
        n_vec++;
        if (unf0 !== 1'b1) begin n_err++; $display("FAIL underrun_c8: got %b expected 1", unf0); end
      end
    end
    n_vec++;
    if (nunf != 3 || nreq != 0 || nones != 0) begin
      n_err++;
      $display("FAIL underrun_counts: got unf=%0d req=%0d sd1=%0d expected 3 0 0", nunf, nreq, nones);
    end
  endtask

  task automatic test_stream();
    logic [31:0] w;
    logic [31:0] fr [0:2];
    int nb, nf, n, nreq, nunf;
    logic pb, pre;
    w = '0; nb = 0; nf = 0; n = 1; nreq = 0; nunf = 0;
    for (int i = 0; i < 3; i++) fr[i] = '0;
    reset0();
    data0 = {16'd1, 16'd1}; valid0 = 1'b1;
    while (cyc < 772) begin
      pre = ready0;
      pb = bclk0;
      tick();
      if (pre) begin
        n++;
        data0 = {n[15:0], n[15:0]};
      end
      if (req0) nreq++;
      if (unf0) nunf++;
      if (cyc > 8 && bclk0 && !pb) begin
        w = {w[30:0], sd0}; nb++;
        if (nb == 32) begin
          if (nf < 3) fr[nf] = w;
          nf++; nb = 0;
        end
      end
      if (cyc == 7 || cyc == 9 || cyc == 263) begin
        n_vec++;
        if (ready0 !== 1'b0) begin n_err++; $display("FAIL stream_ready_low c%0d: got %b expected 0", cyc, ready0); end
      end
      if (cyc == 8 || cyc == 264) begin
        n_vec++;
        if (ready0 !== 1'b1) begin n_err++; $display("FAIL stream_ready_high c%0d: got %b expected 1", cyc, ready0); end
      end
    end
    valid0 = 1'b0;
    n_vec++;
    if (fr[0] !== 32'h0001_0001) begin n_err++; $display("FAIL stream_frame0: got %h expected 00010001", fr[0]); end
    n_vec++;
    if (fr[1] !== 32'h0002_0002) begin n_err++; $display("FAIL stream_frame1: got %h expected 00020002", fr[1]); end
    n_vec++;
    if (fr[2] !== 32'h0003_0003) begin n_err++; $display("FAIL stream_frame2: got %h expected 00030003", fr[2]); end
    n_vec++;
    if (nreq != 3 || nunf != 0) begin
      n_err++; $display("FAIL stream_strobes: got req=%0d unf=%0d expected 3 0", nreq, nunf);
    end
  endtask

  task automatic test_load_collision();
    logic [31:0] w;
    logic [31:0] fr [0:1];
    int nb, nf;
    logic pb;
    w = '0; nb = 0; nf = 0; fr[0] = 32'hFFFF_FFFF; fr[1] = '0;
    reset0();
    while (cyc < 520) begin
      pb = bclk0;
      tick();
      if (cyc > 8 && bclk0 && !pb) begin
        w = {w[30:0], sd0}; nb++;
        if (nb == 32) begin
          if (nf < 2) fr[nf] = w;
          nf++; nb = 0;
        end
      end
      if (cyc == 7) begin
        valid0 = 1'b1; data0 = 32'hDEAD_BEEF;
      end
      if (cyc == 8) begin
        valid0 = 1'b0;
        n_vec++;
        if ({unf0, req0, ready0} !== 3'b100) begin
          n_err++; $display("FAIL collide_load: got unf/req/ready %b expected 100", {unf0, req0, ready0});
        end
      end
      if (cyc == 264) begin
        n_vec++;
        if ({unf0, req0} !== 2'b01) begin
          n_err++; $display("FAIL collide_next_load: got unf/req %b expected 01", {unf0, req0});
        end
      end
    end
    n_vec++;
    if (fr[0] !== 32'h0) begin n_err++; $display("FAIL collide_zero_frame: got %h expected 00000000", fr[0]); end
    n_vec++;
    if (fr[1] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL collide_word_frame: got %h expected deadbeef", fr[1]); end
  endtask

  task automatic test_mid_reset();
    reset0();
    data0 = 32'h1111_2222; valid0 = 1'b1;
    tick();
    data0 = 32'h3333_4444;
    while (cyc < 9) tick();
    valid0 = 1'b0;
    n_vec++;
    if (ready0 !== 1'b0) begin n_err++; $display("FAIL midrst_buffer_full: got ready %b expected 0", ready0); end
    while (cyc < 200) tick();
    n_vec++;
    if (lr0 !== 1'b1) begin n_err++; $display("FAIL midrst_right_slot: got lrclk %b expected 1", lr0); end
    rst0 = 1'b0;
    tick();
    n_vec++;
    if ({ready0, req0, unf0, bclk0, lr0, sd0} !== 6'b100000) begin
      n_err++; $display("FAIL midrst_outputs: got %b expected 100000", {ready0, req0, unf0, bclk0, lr0, sd0});
    end
    rst0 = 1'b1;
    cyc = 0;
    while (cyc < 8) begin
      tick();
      if (cyc == 3) begin
        n_vec++;
        if (bclk0 !== 1'b0) begin n_err++; $display("FAIL midrst_bclk_c3: got %b expected 0", bclk0); end
      end
      if (cyc == 7) begin
        n_vec++;
        if (bclk0 !== 1'b1) begin n_err++; $display("FAIL midrst_bclk_c7: got %b expected 1", bclk0); end
      end
    end
    n_vec++;
    if ({unf0, req0, bclk0} !== 3'b100) begin
      n_err++; $display("FAIL midrst_lost_word: got unf/req/bclk %b expected 100", {unf0, req0, bclk0});
    end
  endtask

  task automatic test_div1();
    logic [47:0] w;
    int nb;
    logic pb;
    w = '0; nb = 0;
    rst1 = 1'b0; valid1 = 1'b0; data1 = '0;
    tick(); tick();
    rst1 = 1'b1;
    cyc = 0;
    data1 = 48'h1234_56AB_CDEF; valid1 = 1'b1;
    while (cyc < 100) begin
      pb = bclk1;
      tick();
      valid1 = 1'b0;
      if (cyc > 2 && bclk1 && !pb && nb < 48) begin
        w = {w[46:0], sd1}; nb++;
      end
      if (cyc == 1 || cyc == 3) begin
        n_vec++;
        if (bclk1 !== 1'b1) begin n_err++; $display("FAIL div1_bclk_high c%0d: got %b expected 1", cyc, bclk1); end
      end
      if (cyc == 2) begin
        n_vec++;
        if ({bclk1, req1, sd1} !== 3'b010) begin
          n_err++; $display("FAIL div1_first_load: got bclk/req/sd %b expected 010", {bclk1, req1, sd1});
        end
      end
      if (cyc == 47 || cyc == 96) begin
        n_vec++;
        if (lr1 !== 1'b0) begin n_err++; $display("FAIL div1_lrclk_low c%0d: got %b expected 0", cyc, lr1); end
      end
      if (cyc == 48 || cyc == 95) begin
        n_vec++;
        if (lr1 !== 1'b1) begin n_err++; $display("FAIL div1_lrclk_high c%0d: got %b expected 1", cyc, lr1); end
      end
      if (cyc == 98) begin
        n_vec++;
        if ({unf1, req1} !== 2'b10) begin
          n_err++; $display("FAIL div1_second_load: got unf/req %b expected 10", {unf1, req1});
        end
      end
    end
    n_vec++;
    if (w !== 48'h1234_56AB_CDEF) begin
      n_err++; $display("FAIL div1_frame: got %h expected 123456abcdef", w);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    rst0 = 1'b0; valid0 = 1'b0; data0 = '0;
    rst1 = 1'b0; valid1 = 1'b0; data1 = '0;
    test_reset();
    test_basic();
    test_underrun();
    test_stream();
    test_load_collision();
    test_mid_reset();
    test_div1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Serializes 32-bit stereo PCM samples into an I2S stream: bit clock, word-select and serial data.
- Sits downstream of the synthesizer. Consumes its {left[31:16], right[15:0]} sample word through a valid/ready handshake.
- Issues a per-frame request strobe, which the synthesizer uses as its sample (DataClock) tick.
- Contains a BCLK divider, a frame bit counter, a one-entry holding buffer and a shift register.

Parameters:
- BCLK_DIV, 4: MasterCLK cycles per BCLK half-period; legal range >= 1.
- SAMPLE_WIDTH, 16: bits per channel slot. Frame length is 2*SAMPLE_WIDTH BCLK periods.

Ports:
- MasterCLK  in  1  system clock; all logic is on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- SampleData  in  2*SAMPLE_WIDTH  [31:16] left, [15:0] right; two's complement.
- SampleValid  in  1  SampleData is valid this cycle.
- SampleReady  out  1  holding buffer is empty; a transfer happens when SampleValid && SampleReady.
- SampleRequest  out  1  one-cycle pulse when the buffer is consumed into the shift register.
- Underrun  out  1  one-cycle pulse when a frame load finds the buffer empty.
- BCLK  out  1  I2S bit clock.
- LRCLK  out  1  I2S word select; 0 = left, 1 = right.
- SDATA  out  1  I2S serial data, MSB first.

Behaviour:
- Reset (Reset=0 at a clock edge) applies to all state, including mid-frame:
  - div_cnt=0, bit_cnt=0; BCLK, LRCLK, SDATA, SampleRequest and Underrun = 0; buffer empty; shift register = 0.
  - SampleReady = 1 from the first cycle after reset.
  - Any in-flight or buffered sample is discarded.
- Divider and BCLK:
  - div_cnt counts 0..BCLK_DIV-1 and wraps. BCLK toggles at each wrap.
  - BCLK period = 2*BCLK_DIV cycles. The first rising edge is BCLK_DIV cycles after reset release.
- Falling-edge event (BCLK 1->0): bit_cnt increments modulo 2*SAMPLE_WIDTH. All of LRCLK, SDATA and the shift register update only on this event.
- LRCLK, registered at the falling edge:
  - 1 when the new bit_cnt is in [SAMPLE_WIDTH, 2*SAMPLE_WIDTH-1]; 0 otherwise.
  - Half period = SAMPLE_WIDTH BCLK periods.
- Frame load (falling edge whose new bit_cnt = 1):
  - If the buffer is full: shreg <= buffer; buffer -> empty; SampleRequest pulses for 1 cycle.
  - If the buffer is empty: shreg <= 0; Underrun pulses for 1 cycle; SampleRequest does not pulse.
  - SDATA <= MSB of the loaded value (left MSB).
- Other falling edges: SDATA <= next bit of shreg, MSB first.
- Bit order within a frame:
  - Left MSB is at bit_cnt=1, left LSB at bit_cnt=SAMPLE_WIDTH (LRCLK already 1).
  - Right MSB is at bit_cnt=SAMPLE_WIDTH+1, right LSB at bit_cnt=0 of the following frame.
  - This gives the standard I2S one-bit delay after each LRCLK transition.
- Handshake:
  - The buffer captures SampleData on valid&&ready. SampleData may change freely when no transfer occurs.
  - SampleReady is combinational ~full; it may stay low for a full frame (backpressure).
  - Accept and frame load in the same cycle: the load sees the pre-cycle buffer state (empty -> zero frame plus Underrun); the accepted word is held for the next frame. There is no bypass.
- Latency: a sample accepted while the buffer is empty starts shifting at the next bit_cnt=1 event.
- Timing at defaults: one frame = 2*SAMPLE_WIDTH*2*BCLK_DIV = 256 MasterCLK cycles.

Test Plan:
1. Defaults, reset release, push 0xA5A5_3C3C before cycle 8.
   - First falling edge at cycle 8: SampleRequest pulse, SDATA=1.
   - SDATA sampled on BCLK rises gives A5A5 (bit_cnt 1..16), then 3C3C (17..31, 0).
   - LRCLK rises on the 16th falling edge; LRCLK period = 256 cycles.
2. Never assert SampleValid.
   - SDATA stays 0.
   - Underrun pulses once per 256 cycles; SampleRequest never pulses.
3. Hold SampleValid=1 with incrementing data 0x0001_0001, 0x0002_0002, ...
   - SampleReady is low exactly between acceptance and the next load.
   - Each frame carries a consecutive word; none skipped or duplicated.
   - One SampleRequest per frame.
4. Assert SampleValid at exactly the load cycle with the buffer empty.
   - That frame is all zeros with Underrun=1.
   - The next frame carries the word.
5. Drive Reset=0 for 1 cycle mid-right-slot with the buffer full.
   - All outputs 0 next cycle; SampleReady=1; buffered word lost.
   - Timing restarts with the first falling edge 8 cycles after release.
6. BCLK_DIV=1, SAMPLE_WIDTH=24.
   - BCLK toggles every cycle; frame = 96 cycles.
   - 0x123456_ABCDEF serializes MSB-first, left then right.
